// File: rtl/alu_ctrl_pkg.sv
// Shared ALU-control definitions: control codes, alu_op encodings, funct7 patterns
// and the sequencer state type.
package alu_ctrl_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9,
        MDU_MUL    = 5'd16,
        MDU_MULH   = 5'd17,
        MDU_MULHSU = 5'd18,
        MDU_MULHU  = 5'd19,
        MDU_DIV    = 5'd20,
        MDU_DIVU   = 5'd21,
        MDU_REM    = 5'd22,
        MDU_REMU   = 5'd23
    } alu_code_e;

    typedef enum logic [1:0] {
        ALU_OP_MEM    = 2'b00,
        ALU_OP_BRANCH = 2'b01,
        ALU_OP_RTYPE  = 2'b10,
        ALU_OP_ITYPE  = 2'b11
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } seq_state_e;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Plain register/immediate ALU mapping used when funct7 carries no modifier.
    function automatic alu_code_e base_code(input logic [2:0] funct3);
        alu_code_e code;
        case (funct3)
            3'b000:  code = ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of {alu_op, funct3, funct7} into an ALU/MDU control code.
// Illegal encodings report ADD with illegal_o set.
module alu_ctrl_dec
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned CTRL_W   = 5,
    parameter bit          ENABLE_M = 1'b1
) (
    input  logic [1:0]        alu_op_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    output logic [CTRL_W-1:0] code_o,
    output logic              is_mdu_o,
    output logic              illegal_o
);

    alu_code_e code;
    logic      is_mdu;
    logic      illegal;

    always_comb begin
        code    = ALU_ADD;
        is_mdu  = 1'b0;
        illegal = 1'b0;
        case (alu_op_e'(alu_op_i))
            ALU_OP_MEM: code = ALU_ADD;
            ALU_OP_BRANCH: begin
                case (funct3_i)
                    3'b000, 3'b001: code = ALU_SUB;
                    3'b100, 3'b101: code = ALU_SLT;
                    3'b110, 3'b111: code = ALU_SLTU;
                    default:        illegal = 1'b1;
                endcase
            end
            ALU_OP_RTYPE: begin
                if (funct7_i == F7_BASE) begin
                    code = base_code(funct3_i);
                end else if (funct7_i == F7_ALT) begin
                    if (funct3_i == 3'b000)      code = ALU_SUB;
                    else if (funct3_i == 3'b101) code = ALU_SRA;
                    else                         illegal = 1'b1;
                end else if (ENABLE_M && funct7_i == F7_MULDIV) begin
                    code   = alu_code_e'({2'b10, funct3_i});
                    is_mdu = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: begin
                // Immediate forms: only shifts look at funct7; ADDI never becomes SUB.
                if (funct3_i == 3'b001) begin
                    if (funct7_i == F7_BASE) code = ALU_SLL;
                    else                     illegal = 1'b1;
                end else if (funct3_i == 3'b101) begin
                    if (funct7_i == F7_BASE)     code = ALU_SRL;
                    else if (funct7_i == F7_ALT) code = ALU_SRA;
                    else                         illegal = 1'b1;
                end else begin
                    code = base_code(funct3_i);
                end
            end
        endcase
    end

    assign code_o    = CTRL_W'(code);
    assign is_mdu_o  = is_mdu;
    assign illegal_o = illegal;

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU-control stage: decodes the op, presents it to EX with valid/ready,
// and sequences multi-cycle MDU ops with stall hold, flush and kill.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned CTRL_W   = 5,
    parameter int unsigned MDU_LAT  = 4,
    parameter bit          ENABLE_M = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [1:0]        alu_op_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    output logic              illegal_o,
    output logic              mdu_start_o,
    output logic              mdu_kill_o
);

    localparam int unsigned CNT_W = $clog2(MDU_LAT + 1);
    localparam logic [CTRL_W-1:0] CTRL_ADD = CTRL_W'(ALU_ADD);

    logic [CTRL_W-1:0] dec_code;
    logic              dec_mdu;
    logic              dec_illegal;

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              illegal_q, illegal_d;
    logic              start_q, start_d;
    logic              kill_q, kill_d;
    logic              accept;

    alu_ctrl_dec #(
        .CTRL_W   (CTRL_W),
        .ENABLE_M (ENABLE_M)
    ) u_dec (
        .alu_op_i  (alu_op_i),
        .funct3_i  (funct3_i),
        .funct7_i  (funct7_i),
        .code_o    (dec_code),
        .is_mdu_o  (dec_mdu),
        .illegal_o (dec_illegal)
    );

    assign ready_o = (state_q == ST_IDLE) && !stall_i && !flush_i;
    assign accept  = valid_i && ready_o;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        start_d   = 1'b0;
        kill_d    = 1'b0;
        if (flush_i) begin
            valid_d   = 1'b0;
            illegal_d = 1'b0;
            ctrl_d    = CTRL_ADD;
            cnt_d     = '0;
            state_d   = ST_IDLE;
            kill_d    = (state_q == ST_WAIT);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A stalled IDLE cycle leaves the presented op untouched.
                    if (!stall_i) begin
                        if (accept && dec_mdu) begin
                            valid_d   = 1'b0;
                            ctrl_d    = dec_code;
                            illegal_d = 1'b0;
                            start_d   = 1'b1;
                            cnt_d     = CNT_W'(MDU_LAT - 1);
                            state_d   = ST_WAIT;
                        end else if (accept) begin
                            valid_d   = 1'b1;
                            ctrl_d    = dec_code;
                            illegal_d = dec_illegal;
                        end else begin
                            valid_d   = 1'b0;
                        end
                    end
                end
                default: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (!stall_i) begin
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            ctrl_q    <= CTRL_ADD;
            illegal_q <= 1'b0;
            start_q   <= 1'b0;
            kill_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            start_q   <= start_d;
            kill_q    <= kill_d;
        end
    end

    assign valid_o     = valid_q;
    assign alu_ctrl_o  = ctrl_q;
    assign illegal_o   = illegal_q;
    assign mdu_start_o = start_q;
    assign mdu_kill_o  = kill_q;

endmodule
